// File: rtl/iter_comp_sequencer_if.sv
// rtl/iter_comp_sequencer_if.sv - request/result bundle for the iterative comparator
interface iter_comp_sequencer_if #(
  parameter int N = 32
);
  localparam int CW = $clog2(N) + 1;

  logic          START;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic          BUSY;
  logic          DONE;
  logic          GT;
  logic          LT;
  logic          EQ;
  logic          Z_out;
  logic          VALID;
  logic [CW-1:0] CYCLES;

  modport master (
    output START, A, B,
    input  BUSY, DONE, GT, LT, EQ, Z_out, VALID, CYCLES
  );

  modport slave (
    input  START, A, B,
    output BUSY, DONE, GT, LT, EQ, Z_out, VALID, CYCLES
  );
endinterface

// File: rtl/iter_comp_sequencer.sv
// rtl/iter_comp_sequencer.sv - bit-serial MSB-first magnitude comparator with optional early exit
module iter_comp_sequencer #(
  parameter int N          = 32,
  parameter int EARLY_EXIT = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  iter_comp_sequencer_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic [N-1:0]  ra_q;
  logic [N-1:0]  rb_q;
  logic [IW-1:0] idx_q;
  logic          x_q;
  logic          y_q;
  logic [CW-1:0] cnt_q;

  logic          gt_q;
  logic          lt_q;
  logic          eq_q;
  logic          z_q;
  logic          valid_q;
  logic [CW-1:0] cycles_q;

  logic          ai;
  logic          bi;
  logic          x_n;
  logic          y_n;
  logic          last_bit;
  logic          busy;
  logic          done;

  // Evaluate the current bit: once one side wins, the other can never win later.
  always_comb begin
    ai       = ra_q[idx_q];
    bi       = rb_q[idx_q];
    x_n      = x_q | (~y_q & ai & ~bi);
    y_n      = y_q | (~x_q & ~ai & bi);
    last_bit = (idx_q == '0) || ((EARLY_EXIT != 0) && (x_n | y_n));
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; START is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.START) state_d = S_SCAN;
      S_SCAN:  if (last_bit) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded straight from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_SCAN:  busy = 1'b1;
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture and the scan datapath (index, win flags, cycle counter).
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ra_q  <= '0;
      rb_q  <= '0;
      idx_q <= '0;
      x_q   <= 1'b0;
      y_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.START) begin
            ra_q  <= bus.A;
            rb_q  <= bus.B;
            idx_q <= IW'(N - 1);
            x_q   <= 1'b0;
            y_q   <= 1'b0;
            cnt_q <= '0;
          end
        end
        S_SCAN: begin
          x_q   <= x_n;
          y_q   <= y_n;
          cnt_q <= cnt_q + 1'b1;
          if (!last_bit) begin
            idx_q <= idx_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers, loaded only on the final scan edge and held otherwise.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      z_q      <= 1'b0;
      valid_q  <= 1'b0;
      cycles_q <= '0;
    end else if (state_q == S_SCAN && last_bit) begin
      gt_q     <= x_n;
      lt_q     <= y_n;
      eq_q     <= ~(x_n | y_n);
      z_q      <= ~x_n;
      valid_q  <= 1'b1;
      cycles_q <= cnt_q + 1'b1;
    end
  end

  assign bus.BUSY   = busy;
  assign bus.DONE   = done;
  assign bus.GT     = gt_q;
  assign bus.LT     = lt_q;
  assign bus.EQ     = eq_q;
  assign bus.Z_out  = z_q;
  assign bus.VALID  = valid_q;
  assign bus.CYCLES = cycles_q;
endmodule

// File: tb/tb_iter_comp_sequencer.sv
// tb/tb_iter_comp_sequencer.sv - scoreboard bench for iter_comp_sequencer (early-exit and full-scan instances)
module tb_iter_comp_sequencer;
  logic CLK = 1'b0;
  logic RESET;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   done0 = 0;
  int   done1 = 0;
  int   busy0 = 0;
  int   busy1 = 0;
  int   n0 = 0;
  int   n1 = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          start;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];

  iter_comp_sequencer_if #(.N(32)) bus0 ();
  iter_comp_sequencer_if #(.N(32)) bus1 ();

  iter_comp_sequencer #(.N(32), .EARLY_EXIT(1)) dut0 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus0)
  );

  iter_comp_sequencer #(.N(32), .EARLY_EXIT(0)) dut1 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus1)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_k(logic [31:0] a, logic [31:0] b, bit ee);
    if (!ee || a == b) return 32;
    for (int i = 31; i >= 0; i--) begin
      if (a[i] != b[i]) return 32 - i;
    end
    return 32;
  endfunction

  task automatic on_done(string id, ent_t e, bit ee, logic gt, logic lt, logic eq,
                         logic z, logic v, logic [5:0] cy, int busy, int now);
    int k;
    k = exp_k(e.a, e.b, ee);
    check({id, " GT"}, 64'(gt), 64'(e.a > e.b));
    check({id, " LT"}, 64'(lt), 64'(e.a < e.b));
    check({id, " EQ"}, 64'(eq), 64'(e.a == e.b));
    check({id, " Z_out"}, 64'(z), 64'(e.a <= e.b));
    check({id, " VALID"}, 64'(v), 64'd1);
    check({id, " CYCLES"}, 64'(cy), 64'(k));
    check({id, " latency"}, 64'(now - e.start), 64'(k));
    check({id, " busy cycles"}, 64'(busy), 64'(k));
  endtask

  always @(negedge CLK) begin
    if (RESET) begin
      busy0 = 0;
    end else begin
      if (bus0.BUSY) busy0++;
      if (bus0.DONE) begin
        if (q0.size() == 0) begin
          check("dut0 unexpected DONE", 64'd1, 64'd0);
        end else begin
          on_done("dut0", q0.pop_front(), 1'b1, bus0.GT, bus0.LT, bus0.EQ,
                  bus0.Z_out, bus0.VALID, bus0.CYCLES, busy0, cyc);
          busy0 = 0;
          done0++;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (RESET) begin
      busy1 = 0;
    end else begin
      if (bus1.BUSY) busy1++;
      if (bus1.DONE) begin
        if (q1.size() == 0) begin
          check("dut1 unexpected DONE", 64'd1, 64'd0);
        end else begin
          on_done("dut1", q1.pop_front(), 1'b0, bus1.GT, bus1.LT, bus1.EQ,
                  bus1.Z_out, bus1.VALID, bus1.CYCLES, busy1, cyc);
          busy1 = 0;
          done1++;
        end
      end
    end
  end

  task automatic drive(logic [31:0] a, logic [31:0] b, logic s);
    bus0.A = a;
    bus0.B = b;
    bus0.START = s;
    bus1.A = a;
    bus1.B = b;
    bus1.START = s;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((done0 < n0 || done1 < n1) && n < 300) begin
      @(posedge CLK);
      n++;
    end
    check("done timeout", 64'((done0 >= n0) && (done1 >= n1)), 64'd1);
  endtask

  task automatic run(logic [31:0] a, logic [31:0] b);
    ent_t e;
    @(negedge CLK);
    drive(a, b, 1'b1);
    e.a = a;
    e.b = b;
    e.start = cyc + 1;
    q0.push_back(e);
    q1.push_back(e);
    n0++;
    n1++;
    @(negedge CLK);
    bus0.START = 1'b0;
    bus1.START = 1'b0;
    wait_done();
  endtask

  initial begin
    ent_t e;
    int   s;
    logic [31:0] r;

    RESET = 1'b1;
    drive(32'd0, 32'd0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    check("reset BUSY", 64'(bus0.BUSY), 64'd0);
    check("reset DONE", 64'(bus0.DONE), 64'd0);
    check("reset flags", 64'({bus0.GT, bus0.LT, bus0.EQ, bus0.Z_out}), 64'd0);
    check("reset VALID", 64'(bus0.VALID), 64'd0);
    check("reset CYCLES", 64'(bus0.CYCLES), 64'd0);
    #1 RESET = 1'b0;

    run(32'd5, 32'd5);
    run(32'h8000_0000, 32'h7FFF_FFFF);
    run(32'd3, 32'd4);
    run(32'd7, 32'd2);
    run(32'hFFFF_FFFF, 32'h0000_0000);
    run(32'h0000_0000, 32'h0000_0001);
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      run(r, r ^ (32'd1 << $urandom_range(0, 31)));
      run($urandom, $urandom);
    end

    // Operands changed and START re-pulsed mid-scan must be ignored.
    @(negedge CLK);
    drive(32'd3, 32'd4, 1'b1);
    e.a = 32'd3;
    e.b = 32'd4;
    e.start = cyc + 1;
    q0.push_back(e);
    q1.push_back(e);
    n0++;
    n1++;
    @(negedge CLK);
    drive(32'd3, 32'd4, 1'b0);
    repeat (3) @(negedge CLK);
    drive(32'hFFFF_FFFF, 32'd0, 1'b1);
    @(negedge CLK);
    drive(32'hFFFF_FFFF, 32'd0, 1'b0);
    wait_done();
    repeat (5) @(negedge CLK);
    check("hold LT", 64'(bus0.LT), 64'd1);
    check("hold GT", 64'(bus0.GT), 64'd0);
    check("hold CYCLES", 64'(bus0.CYCLES), 64'd30);
    check("hold dut1 CYCLES", 64'(bus1.CYCLES), 64'd32);

    // Held START: each instance restarts after exactly one IDLE cycle.
    @(negedge CLK);
    s = cyc + 1;
    drive(32'd7, 32'd2, 1'b1);
    e.a = 32'd7;
    e.b = 32'd2;
    e.start = s;
    q0.push_back(e);
    q1.push_back(e);
    e.start = s + 30 + 2;
    q0.push_back(e);
    e.start = s + 32 + 2;
    q1.push_back(e);
    n0 += 2;
    n1 += 2;
    while (cyc < s + 34) @(negedge CLK);
    drive(32'd7, 32'd2, 1'b0);
    wait_done();

    // Asynchronous reset during the 10th scan cycle aborts with no DONE.
    @(negedge CLK);
    s = cyc + 1;
    drive(32'd3, 32'd4, 1'b1);
    @(negedge CLK);
    drive(32'd3, 32'd4, 1'b0);
    while (cyc < s + 9) @(negedge CLK);
    check("pre-reset BUSY", 64'(bus0.BUSY), 64'd1);
    #1 RESET = 1'b1;
    #1;
    check("async reset BUSY", 64'(bus0.BUSY), 64'd0);
    check("async reset DONE", 64'(bus0.DONE), 64'd0);
    check("async reset flags", 64'({bus0.GT, bus0.LT, bus0.EQ, bus0.Z_out}), 64'd0);
    check("async reset VALID", 64'(bus0.VALID), 64'd0);
    check("async reset CYCLES", 64'(bus0.CYCLES), 64'd0);
    check("async reset dut1 BUSY", 64'(bus1.BUSY), 64'd0);
    @(negedge CLK);
    #1 RESET = 1'b0;
    run(32'd7, 32'd2);
    check("post-reset GT", 64'(bus0.GT), 64'd1);
    check("post-reset Z_out", 64'(bus0.Z_out), 64'd0);
    check("post-reset VALID", 64'(bus0.VALID), 64'd1);

    repeat (40) @(negedge CLK);
    check("q0 drained", 64'(q0.size()), 64'd0);
    check("q1 drained", 64'(q1.size()), 64'd0);
    check("dut0 run count", 64'(done0), 64'(n0));
    check("dut1 run count", 64'(done1), 64'(n1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/iter_comp_sequencer.md
ITER_COMP_SEQUENCER -- requirements
Module: iter_comp_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 32, word width of the operands compared; legal values N >= 4.
REQ-002 The block SHALL have parameter EARLY_EXIT, default 1, where 1 stops the scan at the first differing bit and 0 always scans all N bits.
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit, reset, asynchronous and active-high.
REQ-005 The block SHALL have port START, input, 1 bit, a request to compare A against B.
REQ-006 The block SHALL have port A, input, N bits, first operand (unsigned).
REQ-007 The block SHALL have port B, input, N bits, second operand (unsigned).
REQ-008 The block SHALL have port BUSY, output, 1 bit, high while a scan is in progress.
REQ-009 The block SHALL have port DONE, output, 1 bit, a one-cycle pulse when the result is ready.
REQ-010 The block SHALL have port GT, output, 1 bit, high when A > B.
REQ-011 The block SHALL have port LT, output, 1 bit, high when A < B.
REQ-012 The block SHALL have port EQ, output, 1 bit, high when A == B.
REQ-013 The block SHALL have port Z_out, output, 1 bit, high when A <= B (equals NOT GT), valid with the other results.
REQ-014 The block SHALL have port VALID, output, 1 bit, high once any result has been produced since reset.
REQ-015 The block SHALL have port CYCLES, output, clog2(N)+1 bits, the number of SCAN cycles used by the last comparison.

Function
REQ-016 The FSM SHALL have states IDLE, SCAN and FIN, encoded in registers only.
REQ-017 In IDLE with START=1 at an edge, the block SHALL: capture A/B into internal registers, set idx=N-1, clear internal X (A-greater) and Y (B-greater), clear the cycle counter, and go to SCAN.
REQ-018 The block SHALL ignore START in SCAN and FIN; operand changes after capture SHALL NOT affect the result.
REQ-019 Each SCAN edge SHALL evaluate captured bit idx as X' = X | (~Y & Ai & ~Bi) and Y' = Y | (~X & ~Ai & Bi), then increment the counter.
REQ-020 SCAN SHALL go to FIN when idx==0, or when EARLY_EXIT=1 and (X'|Y')=1; otherwise it SHALL decrement idx and stay in SCAN.
REQ-021 On the SCAN->FIN edge, the block SHALL register GT=X', LT=Y', EQ=~(X'|Y'), Z_out=~X', CYCLES=counter+1 and VALID=1.
REQ-022 FIN SHALL last exactly one cycle with DONE=1, then go to IDLE; DONE SHALL be 0 in every other state.
REQ-023 BUSY SHALL equal 1 exactly in SCAN.
REQ-024 GT/LT/EQ/Z_out/CYCLES SHALL hold between completions; exactly one of GT, LT, EQ SHALL be 1 while VALID=1.
REQ-025 Latency from the START edge to the DONE pulse SHALL be k SCAN edges plus 1 cycle, where k=N if EARLY_EXIT=0, else k = N - (index of the most-significant differing bit), and k=N when A==B.
REQ-026 START held continuously SHALL start a new comparison on the first edge in IDLE after FIN, giving back-to-back operation with one IDLE cycle between runs.

Reset
REQ-027 RESET=1 SHALL immediately force IDLE, clear idx/X/Y/counter, and drive BUSY, DONE, GT, LT, EQ, Z_out, VALID and CYCLES to 0, regardless of CLK.
REQ-028 RESET asserted mid-SCAN SHALL abort the comparison without producing DONE; the first START after release SHALL run normally.

Verification
REQ-029 With N=32, EARLY_EXIT=1, A=B=5: START pulse -> 32 BUSY cycles, then DONE for 1 cycle; EQ=1, Z_out=1, GT=LT=0, CYCLES=32.
REQ-030 With A=0x80000000, B=0x7FFFFFFF: DONE one cycle after the first SCAN edge; GT=1, Z_out=0, CYCLES=1.
REQ-031 With A=3, B=4: GT=0, LT=1, Z_out=1, CYCLES=30; the same run with EARLY_EXIT=0 gives identical flags and CYCLES=32.
REQ-032 Changing A/B and pulsing START during SCAN SHALL NOT change the result or restart the run; a held START re-triggers after exactly one IDLE cycle.
REQ-033 Asserting RESET asynchronously at the 10th SCAN cycle SHALL give all outputs 0 before the next CLK edge and no DONE; after release, A=7, B=2 gives GT=1, Z_out=0, VALID=1.
